// File: rtl/lu_solve_sequencer.sv
// Control sequencer for the 3x3 LU solver: serial coefficient load, run supervision with timeout,
// result/error capture. Define DEFAULT_COEF_EN to make reset preload the demo system and land in READY.
module lu_solve_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coef_valid,
    input  logic [DATA_W-1:0]     coef_data,
    output logic                  coef_ready,
    input  logic                  start,
    input  logic                  clear,
    output logic                  solver_en,
    input  logic                  solver_done,
    input  logic [2:0]            solver_err,
    output logic [12*DATA_W-1:0]  coef_bus,
    input  logic [3*DATA_W-1:0]   x_in,
    output logic [3*DATA_W-1:0]   x_out,
    output logic [3:0]            coef_count,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            err_flags
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_DONE, S_ERROR} state_t;

`ifdef DEFAULT_COEF_EN
    localparam state_t     RST_STATE = S_READY;
    localparam logic [3:0] RST_COUNT = 4'd12;
    localparam logic [15:0] DEMO [12] = '{
        16'h0040, 16'h0080, 16'h0010,
        16'h0010, 16'h0070, 16'hFFD0,
        16'h0020, 16'hFFD0, 16'h0020,
        16'h0020, 16'hFF20, 16'h0020
    };
`else
    localparam state_t     RST_STATE = S_IDLE;
    localparam logic [3:0] RST_COUNT = 4'd0;
`endif

    state_t                state_reg, state_next;
    logic [DATA_W-1:0]     coef_reg [12];
    logic [3:0]            coef_count_reg;
    logic [CNT_W-1:0]      to_cnt_reg;
    logic [3*DATA_W-1:0]   x_out_reg;
    logic [3:0]            err_reg;
    logic                  accept, launch, capture_x, take_err, timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= RST_STATE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        launch      = 1'b0;
        capture_x   = 1'b0;
        take_err    = 1'b0;
        timeout_hit = 1'b0;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_LOAD: begin
                    if (coef_valid) begin
                        accept     = 1'b1;
                        state_next = (coef_count_reg == 4'd11) ? S_READY : S_LOAD;
                    end
                end
                S_READY, S_DONE, S_ERROR: begin
                    if (start) begin
                        launch     = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    // Error outranks completion so a faulty result is never latched.
                    if (|solver_err) begin
                        take_err   = 1'b1;
                        state_next = S_ERROR;
                    end else if (solver_done) begin
                        capture_x  = 1'b1;
                        state_next = S_DONE;
                    end else if (to_cnt_reg == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_next  = S_ERROR;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 12; i++) begin
`ifdef DEFAULT_COEF_EN
                coef_reg[i] <= DATA_W'(DEMO[i]);
`else
                coef_reg[i] <= '0;
`endif
            end
            coef_count_reg <= RST_COUNT;
            to_cnt_reg     <= '0;
            x_out_reg      <= '0;
            err_reg        <= '0;
        end else if (clear) begin
            for (int i = 0; i < 12; i++) coef_reg[i] <= '0;
            coef_count_reg <= '0;
            to_cnt_reg     <= '0;
            err_reg        <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 12; i++)
                    if (coef_count_reg == 4'(i)) coef_reg[i] <= coef_data;
                coef_count_reg <= coef_count_reg + 4'd1;
            end
            if (launch) begin
                to_cnt_reg <= '0;
                err_reg    <= '0;
            end else if (state_reg == S_RUN) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            if (take_err)    err_reg   <= {1'b0, solver_err};
            if (timeout_hit) err_reg   <= 4'b1000;
            if (capture_x)   x_out_reg <= x_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_bus
            assign coef_bus[gi*DATA_W +: DATA_W] = coef_reg[gi];
        end
    endgenerate

    assign coef_ready = (state_reg == S_IDLE) || (state_reg == S_LOAD);
    assign solver_en  = (state_reg == S_RUN);
    assign busy       = (state_reg == S_RUN);
    assign done       = (state_reg == S_DONE);
    assign coef_count = coef_count_reg;
    assign x_out      = x_out_reg;
    assign err_flags  = err_reg;
endmodule

// File: tb/tb_lu_solve_sequencer.sv
// Directed bench for lu_solve_sequencer: one default-timeout instance and one with TIMEOUT_CYC=16,
// both fed from the same stimulus.
module tb_lu_solve_sequencer;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            coef_valid = 1'b0;
    logic [DW-1:0]   coef_data = '0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic            solver_done = 1'b0;
    logic [2:0]      solver_err = 3'b000;
    logic [3*DW-1:0] x_in = '0;

    logic            coef_ready, solver_en, busy, done;
    logic [12*DW-1:0] coef_bus;
    logic [3*DW-1:0] x_out;
    logic [3:0]      coef_count, err_flags;

    logic            coef_ready_t, solver_en_t, busy_t, done_t;
    logic [12*DW-1:0] coef_bus_t;
    logic [3*DW-1:0] x_out_t;
    logic [3:0]      coef_count_t, err_flags_t;

    int checks = 0;
    int failures = 0;

    localparam logic [191:0] DEMO_BUS = {
        16'h0020, 16'hFF20, 16'h0020,
        16'h0020, 16'hFFD0, 16'h0020,
        16'hFFD0, 16'h0070, 16'h0010,
        16'h0010, 16'h0080, 16'h0040
    };
    logic [15:0] demo [12] = '{
        16'h0040, 16'h0080, 16'h0010, 16'h0010, 16'h0070, 16'hFFD0,
        16'h0020, 16'hFFD0, 16'h0020, 16'h0020, 16'hFF20, 16'h0020
    };

`ifdef DEFAULT_COEF_EN
    localparam logic [3:0]   EXP_RST_COUNT = 4'd12;
    localparam logic [191:0] EXP_RST_BUS   = DEMO_BUS;
    localparam logic         EXP_RST_READY = 1'b0;
`else
    localparam logic [3:0]   EXP_RST_COUNT = 4'd0;
    localparam logic [191:0] EXP_RST_BUS   = '0;
    localparam logic         EXP_RST_READY = 1'b1;
`endif

    always #5 clk = ~clk;

    lu_solve_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(4096)) dut (
        .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_data(coef_data),
        .coef_ready(coef_ready), .start(start), .clear(clear), .solver_en(solver_en),
        .solver_done(solver_done), .solver_err(solver_err), .coef_bus(coef_bus),
        .x_in(x_in), .x_out(x_out), .coef_count(coef_count), .busy(busy),
        .done(done), .err_flags(err_flags)
    );

    lu_solve_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .rst(rst), .coef_valid(coef_valid), .coef_data(coef_data),
        .coef_ready(coef_ready_t), .start(start), .clear(clear), .solver_en(solver_en_t),
        .solver_done(solver_done), .solver_err(solver_err), .coef_bus(coef_bus_t),
        .x_in(x_in), .x_out(x_out_t), .coef_count(coef_count_t), .busy(busy_t),
        .done(done_t), .err_flags(err_flags_t)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            coef_valid = 1'b1;
            coef_data  = demo[i];
            step();
            if (gap) begin
                coef_valid = 1'b0;
                coef_data  = 16'hDEAD;
                step();
            end
        end
        coef_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int en_cycles;
        int n;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_count", coef_count, EXP_RST_COUNT);
        check("rst_bus", coef_bus, EXP_RST_BUS);
        check("rst_ready", coef_ready, EXP_RST_READY);
        check("rst_status", {solver_en, busy, done, err_flags, x_out}, '0);
        #10 rst = 1'b1;
        pulse_clear();
        check("idle_ready", coef_ready, 1'b1);

        // 1: full load, 20-cycle solve
        load_words(0, 11, 1'b0);
        check("t1_count", coef_count, 4'd12);
        check("t1_ready_low", coef_ready, 1'b0);
        check("t1_bus", coef_bus, DEMO_BUS);
        x_in = {16'h0060, 16'h0010, 16'hFFD0};
        pulse_start();
        en_cycles = 0;
        if (solver_en) en_cycles++;
        for (int i = 0; i < 19; i++) begin
            step();
            if (solver_en) en_cycles++;
        end
        solver_done = 1'b1;
        step();
        solver_done = 1'b0;
        check("t1_en_cycles", en_cycles, 20);
        check("t1_done", {done, busy, solver_en}, 3'b100);
        check("t1_x_out", x_out, {16'h0060, 16'h0010, 16'hFFD0});

        // 2: gapped load, early start ignored
        pulse_clear();
        check("t2_clear_count", coef_count, 4'd0);
        check("t2_x_kept", x_out, {16'h0060, 16'h0010, 16'hFFD0});
        load_words(0, 4, 1'b1);
        pulse_start();
        check("t2_count5", coef_count, 4'd5);
        check("t2_not_busy", {busy, solver_en, coef_ready}, 3'b001);
        load_words(5, 11, 1'b1);
        check("t2_count12", {coef_count, coef_ready}, {4'd12, 1'b0});
        check("t2_bus", coef_bus, DEMO_BUS);

        // 3: error and done together
        x_in = {16'h1111, 16'h2222, 16'h3333};
        pulse_start();
        step(); step(); step();
        solver_done = 1'b1;
        solver_err  = 3'b010;
        step();
        solver_done = 1'b0;
        solver_err  = 3'b000;
        check("t3_err", err_flags, 4'b0010);
        check("t3_x_kept", x_out, {16'h0060, 16'h0010, 16'hFFD0});
        check("t3_state", {done, busy, solver_en}, 3'b000);

        // 4: timeout on the 16-cycle instance
        pulse_start();
        check("t4_err_cleared", err_flags_t, 4'b0000);
        n = 0;
        while (busy_t && n < 40) begin
            step();
            n++;
        end
        check("t4_cycles", n, 16);
        check("t4_err", {err_flags_t, solver_en_t}, {4'b1000, 1'b0});
        check("t4_long_still_busy", busy, 1'b1);

        // 5: clear mid-run, reload, rerun from DONE
        pulse_clear();
        check("t5_idle", {coef_count, busy, coef_ready, err_flags_t}, {4'd0, 1'b0, 1'b1, 4'd0});
        check("t5_bus_zero", coef_bus, '0);
        load_words(0, 11, 1'b0);
        x_in = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        pulse_start();
        step(); step(); step(); step();
        solver_done = 1'b1;
        step();
        solver_done = 1'b0;
        check("t5_done_x", {done, x_out}, {1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC});
        pulse_start();
        check("t5_rerun", {busy, done, err_flags}, {1'b1, 1'b0, 4'd0});
        solver_err = 3'b001;
        step();
        solver_err = 3'b000;
        check("t5_ovf", err_flags, 4'b0001);
        pulse_start();
        check("t5_err_cleared", {busy, err_flags}, {1'b1, 4'd0});
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        check("t5_clear_prio", {busy, coef_ready, coef_count}, {1'b0, 1'b1, 4'd0});

        // 6: asynchronous reset mid-load
        load_words(0, 2, 1'b0);
        check("t6_count3", coef_count, 4'd3);
        #3 rst = 1'b0;
        #1;
        check("t6_async_count", coef_count, EXP_RST_COUNT);
        check("t6_async_bus", coef_bus, EXP_RST_BUS);
        check("t6_async_x", {x_out, err_flags}, '0);
        check("t6_async_ready", coef_ready, EXP_RST_READY);
        #7 rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
